// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Round-robin arbiter sharing the register-file write port between NREQ
// writeback sources. Grants are combinational. The winning write is staged
// in an output register that drives WE3/A3/WD3 one cycle after the handshake.
// Writes to x0 are consumed but never raise rf_we.

module rf_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_addr,
    output logic [DW-1:0]        rf_wd,
    output logic [2:0]           grant_idx
);

    // The pointer is three bits wide so that any NREQ up to 8 fits.
    logic [2:0]      rr_ptr;
    logic [2:0]      next_ptr;
    logic [7:0]      valid_pad;
    logic [2:0]      idx;
    logic [2:0]      gidx;
    logic            found;
    logic [NREQ-1:0] grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // Zero-extending the valids lets a 3-bit rotated index address them safely.
    assign valid_pad = 8'(req_valid);

    // Search from rr_ptr and wrap modulo NREQ. Then build the one-hot grant and mux the winner.
    always_comb begin
        found    = 1'b0;
        gidx     = 3'd0;
        idx      = 3'd0;
        grant    = '0;
        sel_addr = '0;
        sel_data = '0;
        if (!rst && !flush) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = 3'((int'(rr_ptr) + i) % NREQ);
                if (!found && valid_pad[idx]) begin
                    found = 1'b1;
                    gidx  = idx;
                end
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (found && gidx == 3'(k)) begin
                grant[k] = 1'b1;
                sel_addr = req_addr[k*AW +: AW];
                sel_data = req_data[k*DW +: DW];
            end
        end
    end

    assign req_ready = grant;

    // After a transfer, the requester following the winner gets the next chance.
    assign next_ptr = (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;

    // Output staging register and round-robin pointer. Reset takes priority over flush, which takes priority over transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wd     <= '0;
            grant_idx <= 3'd0;
            rr_ptr    <= 3'd0;
        end else if (flush) begin
            rf_we <= 1'b0;
        end else if (found) begin
            rf_we     <= (sel_addr != '0);
            rf_addr   <= sel_addr;
            rf_wd     <= sel_data;
            grant_idx <= gidx;
            rr_ptr    <= next_ptr;
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Scenario tasks drive the arbiter. A reference model predicts the grant for
// each cycle and queues the register-file write that should appear after the edge.

module tb_rf_write_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 flush;
    logic                 rf_we;
    logic [AW-1:0]        rf_addr;
    logic [DW-1:0]        rf_wd;
    logic [2:0]           grant_idx;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    gidx;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    int            m_ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [2:0]    m_gidx;

    rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wd     (rf_wd),
        .grant_idx (grant_idx)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Reference model: predicts this cycle's grant and queues the staged write expected after the edge.
    task automatic model_cycle(output logic [NREQ-1:0] exp_ready);
        exp_t e;
        int   win;
        win       = -1;
        exp_ready = '0;
        if (!rst && !flush) begin
            for (int i = 0; i < NREQ; i++) begin
                if (win < 0 && req_valid[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
            end
        end
        if (rst) begin
            m_ptr  = 0;
            m_addr = '0;
            m_data = '0;
            m_gidx = 3'd0;
            e.we   = 1'b0;
        end else if (win >= 0) begin
            exp_ready[win] = 1'b1;
            m_addr = req_addr[win*AW +: AW];
            m_data = req_data[win*DW +: DW];
            m_gidx = 3'(win);
            m_ptr  = (win + 1) % NREQ;
            e.we   = (m_addr != '0);
        end else begin
            e.we = 1'b0;
        end
        e.addr = m_addr;
        e.data = m_data;
        e.gidx = m_gidx;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Runs one clock and checks req_ready before the edge and the staged write after it.
    // The name tag identifies the scenario in any failure line.
    task automatic run_cycle(input string tag, output logic [NREQ-1:0] er);
        exp_t e;
        #2;
        model_cycle(er);
        tests++;
        if (req_ready !== er) begin
            fails++;
            $display("[TB] FAIL %s ready: got %b want %b", tag, req_ready, er);
        end
        @(posedge clk);
        #1;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            if ({rf_we, rf_addr, rf_wd, grant_idx} !== {e.we, e.addr, e.data, e.gidx}) begin
                fails++;
                $display("[TB] FAIL %s rf: got we=%b a=%0d d=%h g=%0d want we=%b a=%0d d=%h g=%0d",
                         tag, rf_we, rf_addr, rf_wd, grant_idx, e.we, e.addr, e.data, e.gidx);
            end
        end
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] er;
        rst = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + i);
        for (int c = 0; c < 3; c++) begin
            run_cycle("reset", er);
            tests++;
            if (rf_we !== 1'b0 || rf_addr !== 5'd0 || grant_idx !== 3'd0) begin
                fails++;
                $display("[TB] FAIL reset_state: got we=%b a=%0d g=%0d want 0 0 0", rf_we, rf_addr, grant_idx);
            end
        end
        rst = 1'b0;
        #2;
        tests++;
        if (req_ready !== 3'b001) begin
            fails++;
            $display("[TB] FAIL reset_first_grant: got %b want 001", req_ready);
        end
        run_cycle("reset_release", er);
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] er;
        set_req(0, 1'b1, 5'd5, 32'h0000_0025);
        run_cycle("single", er);
        req_valid = '0;
        tests++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_wd !== 32'h25) begin
            fails++;
            $display("[TB] FAIL single_write: got we=%b a=%0d d=%h want 1 5 00000025", rf_we, rf_addr, rf_wd);
        end
        run_cycle("single_idle", er);
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] er;
        logic [AW-1:0]   addrs [3];
        addrs[0] = 5'd6;
        addrs[1] = 5'd9;
        addrs[2] = 5'd11;
        rst = 1'b1;
        run_cycle("contention_rst", er);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, addrs[i], 32'hC0DE_0000 + i);
        for (int c = 0; c < 7; c++) begin
            #2;
            tests++;
            if (req_ready !== 3'(1 << (c % 3))) begin
                fails++;
                $display("[TB] FAIL contention_order: cycle %0d got %b want %b", c, req_ready, 3'(1 << (c % 3)));
            end
            run_cycle("contention", er);
            tests++;
            if (rf_addr !== addrs[c % 3] || rf_we !== 1'b1) begin
                fails++;
                $display("[TB] FAIL contention_addr: cycle %0d got we=%b a=%0d want 1 %0d", c, rf_we, rf_addr, addrs[c % 3]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_x0();
        logic [NREQ-1:0] er;
        set_req(1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        #2;
        tests++;
        if (req_ready !== 3'b010) begin
            fails++;
            $display("[TB] FAIL x0_ready: got %b want 010", req_ready);
        end
        run_cycle("x0", er);
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL x0_we: got %b want 0", rf_we);
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'd20 + 5'(i), 32'h7700 + i);
        #2;
        tests++;
        if (req_ready !== 3'b100) begin
            fails++;
            $display("[TB] FAIL x0_ptr: got %b want 100", req_ready);
        end
        run_cycle("x0_after", er);
        req_valid = '0;
    endtask

    task automatic test_flush();
        logic [NREQ-1:0] er;
        set_req(2, 1'b1, 5'd17, 32'hF1F1_0002);
        flush = 1'b1;
        #2;
        tests++;
        if (rf_we !== 1'b1) begin
            fails++;
            $display("[TB] FAIL flush_inflight: got %b want 1", rf_we);
        end
        for (int c = 0; c < 2; c++) begin
            run_cycle("flush", er);
            tests++;
            if (rf_we !== 1'b0) begin
                fails++;
                $display("[TB] FAIL flush_we: got %b want 0", rf_we);
            end
        end
        flush = 1'b0;
        #2;
        tests++;
        if (req_ready !== 3'b100) begin
            fails++;
            $display("[TB] FAIL flush_release: got %b want 100", req_ready);
        end
        run_cycle("flush_release", er);
        req_valid = '0;
        tests++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd17 || rf_wd !== 32'hF1F1_0002) begin
            fails++;
            $display("[TB] FAIL flush_write: got we=%b a=%0d d=%h want 1 17 f1f10002", rf_we, rf_addr, rf_wd);
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] er;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'd3 + 5'(i), 32'hAB00 + i);
        run_cycle("midrst_pre", er);
        run_cycle("midrst_pre", er);
        rst = 1'b1;
        run_cycle("midrst", er);
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_we: got %b want 0", rf_we);
        end
        rst = 1'b0;
        #2;
        tests++;
        if (req_ready !== 3'b001) begin
            fails++;
            $display("[TB] FAIL midrst_restart: got %b want 001", req_ready);
        end
        run_cycle("midrst_after", er);
        req_valid = '0;
    endtask

    // Random traffic that respects the handshake: an unserved request holds its valid, addr and data.
    task automatic test_back_to_back();
        logic [NREQ-1:0] er;
        er = '0;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !er[i]))
                    set_req(i, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
            end
            flush = ($urandom_range(0, 7) == 0);
            run_cycle("random", er);
        end
        flush = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        m_ptr     = 0;
        m_addr    = '0;
        m_data    = '0;
        m_gidx    = 3'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
